// File: rtl/dpram_pkg.sv
// Shared constants and requester tags for the layer-0 feature DPRAM port-A arbiter.
package dpram_pkg;

    localparam int ADDR_WIDTH     = 19;
    localparam int ADDR_LINE      = 519168;
    localparam int INOUT_WIDTH    = 128;
    localparam int BYTES_PER_WORD = 16;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WR,
        SRC_RD0,
        SRC_RD1
    } src_t;

endpackage

// File: rtl/dpram_porta_arbiter_if.sv
// Requester handshakes, read return and DPRAM port-A command bundle.
interface dpram_porta_arbiter_if #(
    parameter int ADDR_WIDTH  = dpram_pkg::ADDR_WIDTH,
    parameter int INOUT_WIDTH = dpram_pkg::INOUT_WIDTH
);
    logic                   wr_req;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INOUT_WIDTH-1:0] wr_data;
    logic                   wr_gnt;

    logic                   rd0_req;
    logic [ADDR_WIDTH-1:0]  rd0_addr;
    logic                   rd0_pad;
    logic                   rd0_gnt;
    logic                   rd0_valid;

    logic                   rd1_req;
    logic [ADDR_WIDTH-1:0]  rd1_addr;
    logic                   rd1_pad;
    logic                   rd1_gnt;
    logic                   rd1_valid;

    logic [INOUT_WIDTH-1:0] rd_data;

    logic                   we_a;
    logic [ADDR_WIDTH-1:0]  addr_a;
    logic                   addr_valid;
    logic [INOUT_WIDTH-1:0] din_a;
    logic [INOUT_WIDTH-1:0] dout_a;

    logic                   err_oor;

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd0_req, rd0_addr, rd0_pad,
        output rd1_req, rd1_addr, rd1_pad,
        output dout_a,
        input  wr_gnt, rd0_gnt, rd1_gnt,
        input  rd0_valid, rd1_valid, rd_data,
        input  we_a, addr_a, addr_valid, din_a,
        input  err_oor
    );

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd0_req, rd0_addr, rd0_pad,
        input  rd1_req, rd1_addr, rd1_pad,
        input  dout_a,
        output wr_gnt, rd0_gnt, rd1_gnt,
        output rd0_valid, rd1_valid, rd_data,
        output we_a, addr_a, addr_valid, din_a,
        output err_oor
    );

endinterface

// File: rtl/dpram_porta_arbiter_rd_rr.sv
// Two-way round-robin picker between the systolic row fetchers.
module dpram_rd_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_rd;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (1'b1)
                (req0 && req1):  gnt = last_rd ? 2'b01 : 2'b10;
                (req0 && !req1): gnt = 2'b01;
                (req1 && !req0): gnt = 2'b10;
                default:         gnt = 2'b00;
            endcase
        end
    end

    // Reset to RD1 so the first contested grant goes to RD0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd <= 1'b1;
        end else if (|gnt) begin
            last_rd <= gnt[1];
        end
    end

endmodule

// File: rtl/dpram_porta_arbiter.sv
// Port-A arbiter: writer priority with burst cap, round-robin readers,
// registered command and 2-cycle tagged read return.
module dpram_porta_arbiter #(
    parameter int ADDR_WIDTH   = dpram_pkg::ADDR_WIDTH,
    parameter int ADDR_LINE    = dpram_pkg::ADDR_LINE,
    parameter int INOUT_WIDTH  = dpram_pkg::INOUT_WIDTH,
    parameter int MAX_WR_BURST = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    dpram_porta_arbiter_if.slave bus
);
    import dpram_pkg::*;

    localparam int CW = $clog2(MAX_WR_BURST + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_OK =
        ADDR_WIDTH'(ADDR_LINE - BYTES_PER_WORD);

    logic [CW-1:0]          wr_cnt;
    logic                   any_rd;
    logic                   rd_turn;
    logic                   wr_go;
    logic [1:0]             rd_gnt;
    src_t                   src;
    src_t                   tag;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   sel_pad;
    logic                   oor;

    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   av_q;
    logic [INOUT_WIDTH-1:0] din_q;
    logic                   v0_q;
    logic                   v1_q;
    logic                   err_q;

    // Readers take the slot when the writer is idle or has used its burst.
    always_comb begin
        any_rd  = bus.rd0_req | bus.rd1_req;
        rd_turn = rst_n & any_rd
                & (~bus.wr_req | (wr_cnt == CW'(MAX_WR_BURST)));
        wr_go   = rst_n & bus.wr_req & ~rd_turn;
    end

    dpram_rd_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (bus.rd0_req),
        .req1  (bus.rd1_req),
        .en    (rd_turn),
        .gnt   (rd_gnt)
    );

    always_comb begin
        src      = SRC_NONE;
        sel_addr = bus.rd1_addr;
        sel_pad  = bus.rd1_pad;
        unique case (1'b1)
            wr_go: begin
                src      = SRC_WR;
                sel_addr = bus.wr_addr;
                sel_pad  = 1'b0;
            end
            rd_gnt[0]: begin
                src      = SRC_RD0;
                sel_addr = bus.rd0_addr;
                sel_pad  = bus.rd0_pad;
            end
            rd_gnt[1]: src = SRC_RD1;
            default:   src = SRC_NONE;
        endcase
        oor = sel_addr > LAST_OK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if ((|rd_gnt) || !any_rd) begin
            wr_cnt <= '0;
        end else if (wr_go && (wr_cnt != CW'(MAX_WR_BURST))) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag    <= SRC_NONE;
            we_q   <= 1'b0;
            addr_q <= '0;
            av_q   <= 1'b0;
            din_q  <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tag  <= src;
            we_q <= 1'b0;
            av_q <= 1'b0;
            v0_q <= (tag == SRC_RD0);
            v1_q <= (tag == SRC_RD1);
            if (src == SRC_WR) begin
                we_q   <= ~oor;
                addr_q <= sel_addr;
                din_q  <= bus.wr_data;
            end else if (src != SRC_NONE) begin
                addr_q <= sel_addr;
                av_q   <= ~sel_pad & ~oor;
            end
            if (src != SRC_NONE && oor) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.wr_gnt     = wr_go;
    assign bus.rd0_gnt    = rd_gnt[0];
    assign bus.rd1_gnt    = rd_gnt[1];
    assign bus.we_a       = we_q;
    assign bus.addr_a     = addr_q;
    assign bus.addr_valid = av_q;
    assign bus.din_a      = din_q;
    assign bus.rd0_valid  = v0_q;
    assign bus.rd1_valid  = v1_q;
    assign bus.rd_data    = bus.dout_a;
    assign bus.err_oor    = err_q;

endmodule

// File: tb/tb_dpram_porta_arbiter.sv
// Directed bench for dpram_porta_arbiter with a behavioural port-A DPRAM.
module tb_dpram_porta_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 128;
    localparam int ALINE = 519168;

    localparam logic [DW-1:0] W100 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [DW-1:0] W200 = 128'hDEADBEEF001122334455667788990ABC;
    localparam logic [DW-1:0] WAA  = {16{8'hAA}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic exp_r;

    logic [DW-1:0] mem [32768];

    dpram_porta_arbiter_if #(.ADDR_WIDTH(AW), .INOUT_WIDTH(DW)) bus ();

    dpram_porta_arbiter #(
        .ADDR_WIDTH   (AW),
        .ADDR_LINE    (ALINE),
        .INOUT_WIDTH  (DW),
        .MAX_WR_BURST (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous DPRAM port A: write, then registered read (zero if not valid).
    always @(posedge clk) begin
        if (bus.we_a) mem[bus.addr_a[18:4]] <= bus.din_a;
        bus.dout_a <= bus.addr_valid ? mem[bus.addr_a[18:4]] : '0;
    end

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_wg"}, bus.wr_gnt, 0);
        check({tag, "_g0"}, bus.rd0_gnt, 0);
        check({tag, "_g1"}, bus.rd1_gnt, 0);
        check({tag, "_v0"}, bus.rd0_valid, 0);
        check({tag, "_v1"}, bus.rd1_valid, 0);
        check({tag, "_we"}, bus.we_a, 0);
        check({tag, "_av"}, bus.addr_valid, 0);
        check({tag, "_addr"}, bus.addr_a, 0);
        check({tag, "_din"}, bus.din_a, 0);
        check({tag, "_err"}, bus.err_oor, 0);
    endtask

    initial begin
        for (int j = 0; j < 32768; j++) mem[j] = '0;
        mem[15'h10] = W100;
        mem[15'h20] = W200;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd0_req = 0; bus.rd0_addr = '0; bus.rd0_pad = 0;
        bus.rd1_req = 0; bus.rd1_addr = '0; bus.rd1_pad = 0;
        bus.dout_a = '0;

        #12;
        all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Contested readers alternate, returns follow two cycles later.
        bus.rd0_addr = 19'h100;
        bus.rd1_addr = 19'h200;
        for (int i = 0; i < 8; i++) begin
            bus.rd0_req = (i < 6);
            bus.rd1_req = (i < 6);
            #1;
            if (i < 6) begin
                check("rr_g0", bus.rd0_gnt, (i % 2) == 0);
                check("rr_g1", bus.rd1_gnt, (i % 2) == 1);
                check("rr_we", bus.we_a, 0);
            end
            if (i >= 2) begin
                check("rr_v0", bus.rd0_valid, ((i - 2) % 2) == 0);
                check("rr_v1", bus.rd1_valid, ((i - 2) % 2) == 1);
                check("rr_data", bus.rd_data, ((i - 2) % 2) == 0 ? W100 : W200);
            end
            tick();
        end

        // Single read of 0x100.
        bus.rd0_req = 1;
        #1 check("rd_g0", bus.rd0_gnt, 1);
        tick();
        bus.rd0_req = 0;
        check("rd_addr", bus.addr_a, 19'h100);
        check("rd_av", bus.addr_valid, 1);
        check("rd_v0_early", bus.rd0_valid, 0);
        tick();
        check("rd_v0", bus.rd0_valid, 1);
        check("rd_data", bus.rd_data, W100);
        tick();
        check("rd_v0_end", bus.rd0_valid, 0);

        // Writer against a waiting reader: 8 writes then one read.
        bus.rd1_addr = 19'h300;
        for (int i = 0; i < 20; i++) begin
            bus.wr_req = 1;
            bus.rd1_req = 1;
            bus.wr_addr = AW'(32'h1000 + i * 16);
            bus.wr_data = DW'(i);
            #1;
            exp_r = (i == 8) || (i == 17);
            check("burst_wg", bus.wr_gnt, !exp_r);
            check("burst_rg", bus.rd1_gnt, exp_r);
            tick();
        end
        bus.wr_req = 0;
        bus.rd1_req = 0;
        tick(); tick(); tick();
        check("burst_mem", mem[15'h100 + 15'd3], 3);

        // Read-after-write on consecutive grants.
        bus.wr_req = 1;
        bus.wr_addr = 19'h40;
        bus.wr_data = WAA;
        #1 check("raw_wg", bus.wr_gnt, 1);
        tick();
        bus.wr_req = 0;
        bus.rd0_req = 1;
        bus.rd0_addr = 19'h40;
        #1 check("raw_rg", bus.rd0_gnt, 1);
        check("raw_we", bus.we_a, 1);
        check("raw_din", bus.din_a, WAA);
        check("raw_wav", bus.addr_valid, 0);
        tick();
        bus.rd0_req = 0;
        check("raw_av", bus.addr_valid, 1);
        tick();
        check("raw_v", bus.rd0_valid, 1);
        check("raw_data", bus.rd_data, WAA);
        tick();

        // Padding read of nonzero contents.
        bus.rd0_req = 1;
        bus.rd0_pad = 1;
        bus.rd0_addr = 19'h200;
        #1 check("pad_g", bus.rd0_gnt, 1);
        tick();
        bus.rd0_req = 0;
        bus.rd0_pad = 0;
        check("pad_av", bus.addr_valid, 0);
        check("pad_addr", bus.addr_a, 19'h200);
        tick();
        check("pad_v", bus.rd0_valid, 1);
        check("pad_data", bus.rd_data, 0);
        check("pad_err", bus.err_oor, 0);

        // Last legal word is not out of range.
        bus.rd0_req = 1;
        bus.rd0_addr = AW'(ALINE - 16);
        #1 check("edge_g", bus.rd0_gnt, 1);
        tick();
        bus.rd0_req = 0;
        check("edge_av", bus.addr_valid, 1);
        tick();
        check("edge_err", bus.err_oor, 0);

        // One byte past: granted, zero data, sticky error.
        bus.rd1_req = 1;
        bus.rd1_addr = AW'(ALINE - 15);
        #1 check("oor_g", bus.rd1_gnt, 1);
        tick();
        bus.rd1_req = 0;
        check("oor_av", bus.addr_valid, 0);
        check("oor_err", bus.err_oor, 1);
        tick();
        check("oor_v", bus.rd1_valid, 1);
        check("oor_data", bus.rd_data, 0);

        bus.wr_req = 1;
        bus.wr_addr = AW'(ALINE - 15);
        bus.wr_data = WAA;
        #1 check("oorw_g", bus.wr_gnt, 1);
        tick();
        bus.wr_req = 0;
        check("oorw_we", bus.we_a, 0);
        tick(); tick();
        check("oor_sticky", bus.err_oor, 1);

        // Reset right after a read grant drops the return and the RR state.
        bus.rd0_req = 1;
        bus.rd0_addr = 19'h100;
        #1 check("rst_pre_g", bus.rd0_gnt, 1);
        tick();
        rst_n = 1'b0;
        bus.rd1_req = 1;
        #1 all_zero("rst");
        tick();
        check("rst_v0_a", bus.rd0_valid, 0);
        tick();
        check("rst_v0_b", bus.rd0_valid, 0);
        rst_n = 1'b1;
        #1 check("rst_rr_g0", bus.rd0_gnt, 1);
        check("rst_rr_g1", bus.rd1_gnt, 0);
        tick();
        bus.rd0_req = 0;
        bus.rd1_req = 0;
        check("rst_post_v0", bus.rd0_valid, 0);
        tick();
        check("rst_post_v0b", bus.rd0_valid, 1);
        check("rst_post_data", bus.rd_data, W100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_porta_arbiter.md
# dpram_porta_arbiter

Shares port A of the layer-0 feature DPRAM (128-bit words, byte-addressed, 16 bytes per access) between one writer (the input-feature loader) and two readers (the systolic-array row fetchers RD0/RD1). Grants at most one access per cycle, registers the port-A command, and returns read data tagged to the issuing reader with fixed 2-cycle latency. Padding reads issue with `addr_valid` low so the RAM returns zero; out-of-range accesses are suppressed and flagged.

## Interface
Parameters:
- `ADDR_WIDTH`, 19, byte address width
- `ADDR_LINE`, 519168, RAM depth in bytes (416x416x3)
- `INOUT_WIDTH`, 128, data word width
- `MAX_WR_BURST`, 8, consecutive write grants allowed while any reader waits

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `wr_req` in 1: write request, held until granted
- `wr_addr` in ADDR_WIDTH: write byte address
- `wr_data` in INOUT_WIDTH: write data
- `wr_gnt` out 1: write accepted this edge
- `rdK_req` in 1 (K=0,1): read request, held until granted
- `rdK_addr` in ADDR_WIDTH: read byte address
- `rdK_pad` in 1: padding read, return zero
- `rdK_gnt` out 1: read accepted this edge
- `rdK_valid` out 1: `rd_data` belongs to reader K this cycle
- `rd_data` out INOUT_WIDTH: read data, shared by both readers
- `we_a` out 1, `addr_a` out ADDR_WIDTH, `addr_valid` out 1, `din_a` out INOUT_WIDTH: port-A command to DPRAM
- `dout_a` in INOUT_WIDTH: DPRAM port-A read data
- `err_oor` out 1: sticky, an access with addr > ADDR_LINE-16 was accepted

## Operation
- Grants are combinational from requests and state. A transfer occurs at an edge where `req && gnt` holds. At most one grant per cycle.
- Priority: the writer wins. Exception: when `wr_cnt == MAX_WR_BURST` and any reader requests, readers win one grant.
- `wr_cnt` increments on each write grant while any `rdK_req` is high. It clears on any read grant, or on a cycle with no reader request. It saturates at MAX_WR_BURST.
- Readers are round-robin. Pointer `last_rd` updates on each read grant. When both readers request, the reader other than `last_rd` wins. Reset value of `last_rd` is 1, so RD0 wins first.
- Command register, loaded at the accepting edge:
  - Write: `we_a`=1, `addr_a`=`wr_addr`, `din_a`=`wr_data`, `addr_valid`=0.
  - Read: `we_a`=0, `addr_a`=`rdK_addr`, `addr_valid`=!`rdK_pad`.
  - No grant: `we_a`=0, `addr_valid`=0; `addr_a` and `din_a` hold.
- Out of range (addr > ADDR_LINE-16): the access is still granted, and `err_oor` sets.
  - Write: `we_a` is forced to 0.
  - Read: `addr_valid` is forced to 0, so zero data returns.
- Read-return pipeline is two stages: tag valid/id, then `rdK_valid`. `rd_data` = `dout_a` passthrough.
- Writes produce no response.

## Timing
- Read latency: accept at edge E0 → port A driven in cycle E0..E1 → DPRAM captures at E1 → `rdK_valid`=1 and `rd_data` valid in cycle E1..E2.
- Throughput: one access per cycle, back-to-back, any mix of requesters.
- Read-after-write to the same address in consecutive grants returns the new data, because the DPRAM write lands at E1 before the read samples at E2.
- Reset (async, any time), all outputs go to 0:
  - `wr_gnt`, `rdK_gnt`, `rdK_valid`, `we_a`, `addr_valid`, `addr_a`, `din_a`, `err_oor` = 0.
  - `wr_cnt`=0, `last_rd`=1.
  - In-flight reads are dropped; no `rdK_valid` follows the release of reset.
- A requester deasserting `req` without a grant is legal; nothing is issued for it.
- `err_oor` clears only on reset.

## Structure
- Shared package `dpram_pkg`:
  - ADDR_WIDTH, ADDR_LINE, INOUT_WIDTH, BYTES_PER_WORD=16
  - requester enum `{SRC_NONE, SRC_WR, SRC_RD0, SRC_RD1}`, used for the command/return tag
- One sub-module, `dpram_rd_rr`: 2-way round-robin picker with `last_rd` state; inputs are the two reqs and an enable; output is a one-hot grant.
- The top level holds priority/starvation logic, command register, return pipeline and range check.

## Test plan
- RD0 alone reads addr 0x100 with memory preloaded 0x0F..0x00 → `rd0_gnt` at E0, `rd0_valid` at E1..E2 with `rd_data`=0x0F0E..0100; `we_a`=0 throughout.
- RD0 and RD1 both request continuously for 6 cycles → grants alternate RD0, RD1, RD0…; returns alternate with matching `rdK_valid` 2 cycles later.
- `wr_req` and `rd1_req` held high for 20 cycles, MAX_WR_BURST=8 → 8 write grants, 1 RD1 grant, 8 writes, 1 RD1 grant, and so on.
- Write 0xAA..AA to addr 0x40, then read 0x40 on the next cycle → read returns 0xAA..AA.
- `rd0_pad`=1 at addr 0x200 (nonzero contents) → `addr_valid`=0, `rd_data`=0. A read at addr ADDR_LINE-15 → zero data and `err_oor`=1, which stays set.
- Assert `rst_n`=0 one cycle after a read grant → `rd0_valid` never rises; all outputs 0; after release, first contested read goes to RD0.
